fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_if.sv | 45 ++++
 rtl/fwd_scoreboard.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle of signals between the decode stage and the forwarding scoreboard.
// The decode stage drives the master side and the scoreboard sits on the slave side.
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 3
);
  // Decode-stage instruction description
  logic                    iss_valid;
  logic [AW-1:0]           iss_rd;
  logic                    iss_wr;
  logic                    iss_load;
  logic [AW-1:0]           src_a;
  logic [AW-1:0]           src_b;
  logic                    use_a;
  logic                    use_b;
  logic                    flush;

  // Candidate operand data: register file and in-flight stage results
  logic [DATA_W-1:0]       rf_a;
  logic [DATA_W-1:0]       rf_b;
  logic [DEPTH*DATA_W-1:0] stage_data;

  // Scoreboard results
  logic [DATA_W-1:0]       opnd_a;
  logic [DATA_W-1:0]       opnd_b;
  logic                    fwd_hit_a;
  logic                    fwd_hit_b;
  logic                    stall;
  logic [15:0]             stall_cnt;

  modport master (
    output iss_valid, iss_rd, iss_wr, iss_load,
    output src_a, src_b, use_a, use_b, flush,
    output rf_a, rf_b, stage_data,
    input  opnd_a, opnd_b, fwd_hit_a, fwd_hit_b, stall, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_rd, iss_wr, iss_load,
    input  src_a, src_b, use_a, use_b, flush,
    input  rf_a, rf_b, stage_data,
    output opnd_a, opnd_b, fwd_hit_a, fwd_hit_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard with load-use hazard detection.
// Tracks destination tags of the DEPTH instructions behind decode (index 0 = EX,
// DEPTH-1 = WB), picks the youngest in-flight writer of each source register and
// either forwards that stage's result or, for a load whose data is not yet
// available, stalls decode. The interface parameters must match DATA_W/AW/DEPTH.
module fwd_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  fwd_scoreboard_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject parameter combinations outside the supported range at elaboration.
  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH must be in 2..8");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > DEPTH - 1) begin : g_bad_lat
    $error("fwd_scoreboard: LOAD_LAT must be in 1..DEPTH-1");
  end

  // Extract the result of stage idx from the packed stage bus.
  function automatic logic [DATA_W-1:0] pick_stage(
    input logic [DEPTH*DATA_W-1:0] data,
    input logic [IW-1:0]           idx
  );
    pick_stage = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == IW'(i)) pick_stage = data[i*DATA_W +: DATA_W];
    end
  endfunction

  // Tag pipeline: valid is control (reset), rd/load are only meaningful when valid.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  // Lookup results per source
  logic             hit_a, hit_b;
  logic [IW-1:0]    idx_a, idx_b;
  logic             pend_a, pend_b;
  logic             stall;
  logic             ins;

  // Youngest-writer search: scan from oldest to youngest so the lowest index wins.
  always_comb begin
    hit_a = 1'b0;
    idx_a = '0;
    hit_b = 1'b0;
    idx_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (rd_q[i] == bus.src_a) && (bus.src_a != '0)) begin
        hit_a = 1'b1;
        idx_a = IW'(i);
      end
      if (vld_q[i] && (rd_q[i] == bus.src_b) && (bus.src_b != '0)) begin
        hit_b = 1'b1;
        idx_b = IW'(i);
      end
    end
  end

  // A selected writer is pending when it is a load that has not reached LOAD_LAT.
  always_comb begin
    pend_a = hit_a && ld_q[idx_a] && (int'(idx_a) < LOAD_LAT);
    pend_b = hit_b && ld_q[idx_b] && (int'(idx_b) < LOAD_LAT);
    stall  = bus.iss_valid && ((bus.use_a && pend_a) || (bus.use_b && pend_b));
    // A stalled or flushed instruction must not leave a tag behind.
    ins    = bus.iss_valid && bus.iss_wr && (bus.iss_rd != '0) && !bus.flush && !stall;
  end

  // Operand muxes: forward ready stage data, otherwise fall back to the register file.
  always_comb begin
    bus.opnd_a    = bus.rf_a;
    bus.fwd_hit_a = 1'b0;
    bus.opnd_b    = bus.rf_b;
    bus.fwd_hit_b = 1'b0;
    if (hit_a && !pend_a) begin
      bus.opnd_a    = pick_stage(bus.stage_data, idx_a);
      bus.fwd_hit_a = 1'b1;
    end
    if (hit_b && !pend_b) begin
      bus.opnd_b    = pick_stage(bus.stage_data, idx_b);
      bus.fwd_hit_b = 1'b1;
    end
    bus.stall     = stall;
    bus.stall_cnt = stall_cnt_q;
  end

  // Next tag state: new tag (or bubble) enters EX, everything else ages by one stage.
  always_comb begin
    vld_d    = '0;
    ld_d     = '0;
    vld_d[0] = ins;
    ld_d[0]  = bus.iss_load;
    rd_d[0]  = bus.iss_rd;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      ld_d[i]  = ld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Control state: tag valids and stall counter, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Tag payload: qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ld_q <= ld_d;
    for (int i = 0; i < DEPTH; i++) begin
      rd_q[i] <= rd_d[i];
    end
  end

endmodule
